mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Memory-side consumer of the 3-bit mem_width code from the load/store decoder.
//  Accepts one load/store request from the execute stage and runs a req/gnt/rvalid data-memory transaction.
//  For stores: generates word-aligned address, byte enables and lane-replicated write data.
//  For loads: extracts the addressed byte/half/word and sign/zero-extends it into a 32-bit result.
// PARAMETERS
//  ADDR_W   32  byte-address width
//  DATA_W   32  data width; fixed at 32, 4 byte lanes
// PORTS
//  clk         in   1   single clock; all state updates on rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  req_valid   in   1   request offered by execute stage
//  req_ready   out  1   unit idle, request accepted when valid&ready
//  req_we      in   1   1=store 0=load
//  req_width   in   3   000 B, 001 H, 010 W, 100 BU, 101 HU; other codes treated as W
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, value in low bits
//  resp_valid  out  1   one-cycle pulse: access complete
//  resp_rdata  out  32  extended load data (0 for stores)
//  resp_fault  out  1   misaligned access (MISALIGN_TRAP_EN only)
//  dmem_req    out  1   bus request, held until dmem_gnt
//  dmem_gnt    in   1   bus grant
//  dmem_we     out  1   bus write
//  dmem_addr   out  32  {req_addr[31:2],2'b00}
//  dmem_be     out  4   byte enables
//  dmem_wdata  out  32  lane-replicated store data
//  dmem_rvalid in   1   read data / write ack valid
//  dmem_rdata  in   32  raw bus word
// BEHAVIOUR
//  - Reset: state=IDLE; req_ready=1; resp_valid, resp_fault, dmem_req, dmem_we=0; resp_rdata, dmem_addr, dmem_be, dmem_wdata=0.
//  - FSM: IDLE -(valid&ready)-> REQ -(gnt)-> WAIT -(rvalid)-> RESP -> IDLE.
//  - Request fields are registered on acceptance; they are stable for the whole transaction.
//  - req_ready=1 only in IDLE.
//  - Bus fields are driven from the registered request while in REQ.
//  - gnt and rvalid in the same cycle in REQ: go straight to RESP.
//  - Minimum latency: accept at cycle 0, resp_valid at cycle 3 (gnt in cycle 1, rvalid in cycle 2).
//  - Stores complete on rvalid (write ack).
//  - dmem_rvalid/dmem_gnt outside REQ/WAIT: ignored.
//  - Byte enables and write data, with o=addr[1:0]:
//    - B: be=4'b0001<<o; wdata={4{wdata[7:0]}}.
//    - H: be=4'b0011<<{o[1],1'b0}; wdata={2{wdata[15:0]}}.
//    - W: be=4'b1111; wdata as given.
//    - Width bit2 is ignored for stores.
//  - Load extract: lane = dmem_rdata >> (8*o).
//    - B/H: sign-extend bit 7/15.
//    - BU/HU: zero-extend.
//    - W: pass through.
//    - The result is registered into resp_rdata in RESP.
//  - Reset mid-transaction: immediately IDLE, outputs to reset values, no response is issued.
//    - A late rvalid arriving after reset is ignored.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//   - H with addr[0]=1, or W with addr[1:0]!=0, issues no bus transaction.
//   - FSM goes IDLE->RESP; resp_valid=1, resp_fault=1, resp_rdata=0 one cycle after accept.
//  MISALIGN_TRAP_EN undefined:
//   - resp_fault tied 0.
//   - Misaligned address is forced to natural alignment (H clears bit0, W clears bits1:0), then the access proceeds.
// STRUCTURE
//  - Package mem_pkg:
//    - mem_width_e enum (MW_B=3'b000, MW_H=3'b001, MW_W=3'b010, MW_BU=3'b100, MW_HU=3'b101).
//    - mau_state_e enum (IDLE, REQ, WAIT, RESP).
//    - Lane constants.
//    - Shared with load_store_decoder.
//  - Sub-module load_extend: combinational (rdata, offset, width) -> extended 32-bit value.
// TESTING
//  1. LB at 0x1003 with rdata=0x80FF_1234 -> be ignored, resp_rdata=0xFFFF_FF80; LBU same -> 0x0000_0080.
//  2. SH at 0x2002 with wdata=0x0000_BEEF -> dmem_addr=0x2000, be=4'b1100, dmem_wdata=0xBEEF_BEEF, dmem_we=1.
//  3. LW at 0x3000, gnt held low 5 cycles -> dmem_req stays 1 with stable fields; resp_valid 1 cycle after rvalid.
//  4. gnt and rvalid same cycle -> resp_valid next cycle; back-to-back request accepted the cycle after.
//  5. rst_n low while in WAIT, then rvalid after release -> no resp_valid, req_ready=1, all outputs at reset values.
//  6. LW at 0x4002:
//     - with MISALIGN_TRAP_EN -> no dmem_req, resp_fault=1.
//     - without -> dmem_addr=0x4000, be=4'b1111, resp_fault=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared load/store width codes, unit FSM states and lane constants.
// Imported by mem_access_unit, load_extend and the load/store decoder.
package mem_pkg;

    typedef enum logic [2:0] {
        MW_B  = 3'b000,
        MW_H  = 3'b001,
        MW_W  = 3'b010,
        MW_BU = 3'b100,
        MW_HU = 3'b101
    } mem_width_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } mau_state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } mem_size_e;

    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 8;

    // Bit 2 only selects signedness; codes outside B/H collapse to a word access.
    function automatic mem_size_e mw_size(input logic [2:0] width);
        case (width[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory req/gnt/rvalid bus; master = mem_access_unit, slave = memory.
interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    logic                  dmem_req;
    logic                  dmem_gnt;
    logic                  dmem_we;
    logic [ADDR_W-1:0]     dmem_addr;
    logic [DATA_W/8-1:0]   dmem_be;
    logic [DATA_W-1:0]     dmem_wdata;
    logic                  dmem_rvalid;
    logic [DATA_W-1:0]     dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );

endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Load result formatting: selects the addressed lane of a bus word and
// sign- or zero-extends it according to the width code.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  width_i,
    output logic [31:0] data_o
);

    logic [31:0] lane;
    logic        sext;

    always_comb begin
        lane   = rdata_i >> {offset_i, 3'b000};
        sext   = ~width_i[2];
        data_o = lane;
        case (mw_size(width_i))
            SZ_B:    data_o = {{24{sext & lane[7]}}, lane[7:0]};
            SZ_H:    data_o = {{16{sext & lane[15]}}, lane[15:0]};
            default: data_o = lane;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit driving a req/gnt/rvalid data-memory bus.
// Define MISALIGN_TRAP_EN to fault misaligned H/W accesses instead of aligning them.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_width,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [DATA_W-1:0]  req_wdata,
    output logic               resp_valid,
    output logic [DATA_W-1:0]  resp_rdata,
    output logic               resp_fault,
    mem_access_unit_if.master  dmem
);

    mau_state_e          state_q;
    logic                we_q;
    logic [2:0]          width_q;
    logic [1:0]          off_q;
    logic                dmem_req_q;
    logic                dmem_we_q;
    logic [ADDR_W-1:0]   dmem_addr_q;
    logic [LANES-1:0]    dmem_be_q;
    logic [DATA_W-1:0]   dmem_wdata_q;
    logic                resp_valid_q;
    logic                resp_fault_q;
    logic [DATA_W-1:0]   resp_rdata_q;

    mem_size_e           size_d;
    logic [1:0]          off_d;
    logic [LANES-1:0]    be_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [ADDR_W-1:0]   addr_d;
    logic                trap_d;
    logic                done_d;
    logic [DATA_W-1:0]   ext_data;

    // Offset is forced to natural alignment; with trapping enabled a
    // misaligned request never reaches the bus, so the forcing is harmless.
    always_comb begin
        size_d  = mw_size(req_width);
        addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
        off_d   = 2'b00;
        be_d    = '1;
        wdata_d = req_wdata;
        case (size_d)
            SZ_B: begin
                off_d   = req_addr[1:0];
                be_d    = 4'b0001 << req_addr[1:0];
                wdata_d = {LANES{req_wdata[LANE_W-1:0]}};
            end
            SZ_H: begin
                off_d   = {req_addr[1], 1'b0};
                be_d    = 4'b0011 << {req_addr[1], 1'b0};
                wdata_d = {2{req_wdata[2*LANE_W-1:0]}};
            end
            default: ;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign trap_d = ((size_d == SZ_H) && req_addr[0]) ||
                    ((size_d == SZ_W) && (req_addr[1:0] != 2'b00));
`else
    assign trap_d = 1'b0;
`endif

    assign done_d = dmem.dmem_rvalid &&
                    (((state_q == REQ) && dmem.dmem_gnt) || (state_q == WAIT));

    load_extend u_load_extend (
        .rdata_i  (dmem.dmem_rdata),
        .offset_i (off_q),
        .width_i  (width_q),
        .data_o   (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            width_q      <= '0;
            off_q        <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= '0;
            dmem_wdata_q <= '0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    width_q <= req_width;
                    off_q   <= off_d;
                    if (trap_d) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_fault_q <= 1'b1;
                        resp_rdata_q <= '0;
                    end else begin
                        state_q      <= REQ;
                        dmem_req_q   <= 1'b1;
                        dmem_we_q    <= req_we;
                        dmem_addr_q  <= addr_d;
                        dmem_be_q    <= be_d;
                        dmem_wdata_q <= wdata_d;
                    end
                end
                REQ: if (dmem.dmem_gnt) begin
                    dmem_req_q   <= 1'b0;
                    dmem_we_q    <= 1'b0;
                    dmem_addr_q  <= '0;
                    dmem_be_q    <= '0;
                    dmem_wdata_q <= '0;
                    state_q      <= dmem.dmem_rvalid ? RESP : WAIT;
                end
                WAIT: if (dmem.dmem_rvalid) state_q <= RESP;
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_fault_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
            if (done_d) begin
                resp_valid_q <= 1'b1;
                resp_rdata_q <= we_q ? '0 : ext_data;
            end
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_fault      = resp_fault_q;
    assign dmem.dmem_req   = dmem_req_q;
    assign dmem.dmem_we    = dmem_we_q;
    assign dmem.dmem_addr  = dmem_addr_q;
    assign dmem.dmem_be    = dmem_be_q;
    assign dmem.dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed-vector bench for mem_access_unit; honours MISALIGN_TRAP_EN like the RTL.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_width;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    int unsigned n_vec;
    int unsigned n_err;

    mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) dmem_bus ();

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_width  (req_width),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .dmem       (dmem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, ":ready"},  {31'b0, req_ready},          32'd1);
        check_eq({tag, ":rvalid"}, {31'b0, resp_valid},         32'd0);
        check_eq({tag, ":fault"},  {31'b0, resp_fault},         32'd0);
        check_eq({tag, ":rdata"},  resp_rdata,                  32'd0);
        check_eq({tag, ":dreq"},   {31'b0, dmem_bus.dmem_req},  32'd0);
        check_eq({tag, ":dwe"},    {31'b0, dmem_bus.dmem_we},   32'd0);
        check_eq({tag, ":daddr"},  dmem_bus.dmem_addr,          32'd0);
        check_eq({tag, ":dbe"},    {28'b0, dmem_bus.dmem_be},   32'd0);
        check_eq({tag, ":dwdata"}, dmem_bus.dmem_wdata,         32'd0);
    endtask

    // One complete transaction; gnt_wait cycles of withheld grant, optional gnt+rvalid together.
    task automatic run_access(input string tag, input logic we, input logic [2:0] w,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                              input logic [31:0] exp_addr, input logic [3:0] exp_be,
                              input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                              input int unsigned gnt_wait, input bit same_cycle);
        check_eq({tag, ":ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_width = w;
        req_addr  = a;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
        check_eq({tag, ":dreq"},  {31'b0, dmem_bus.dmem_req}, 32'd1);
        check_eq({tag, ":dwe"},   {31'b0, dmem_bus.dmem_we},  {31'b0, we});
        check_eq({tag, ":daddr"}, dmem_bus.dmem_addr,         exp_addr);
        check_eq({tag, ":dbe"},   {28'b0, dmem_bus.dmem_be},  {28'b0, exp_be});
        if (we) check_eq({tag, ":dwdata"}, dmem_bus.dmem_wdata, exp_wd);
        for (int unsigned i = 0; i < gnt_wait; i++) begin
            tick();
            check_eq({tag, ":hold_req"},  {31'b0, dmem_bus.dmem_req}, 32'd1);
            check_eq({tag, ":hold_addr"}, dmem_bus.dmem_addr,         exp_addr);
            check_eq({tag, ":hold_be"},   {28'b0, dmem_bus.dmem_be},  {28'b0, exp_be});
        end
        dmem_bus.dmem_gnt = 1'b1;
        if (same_cycle) begin
            dmem_bus.dmem_rvalid = 1'b1;
            dmem_bus.dmem_rdata  = rd;
        end
        tick();
        dmem_bus.dmem_gnt = 1'b0;
        if (!same_cycle) begin
            check_eq({tag, ":wait_dreq"},   {31'b0, dmem_bus.dmem_req}, 32'd0);
            check_eq({tag, ":wait_rvalid"}, {31'b0, resp_valid},        32'd0);
            dmem_bus.dmem_rvalid = 1'b1;
            dmem_bus.dmem_rdata  = rd;
            tick();
        end
        dmem_bus.dmem_rvalid = 1'b0;
        dmem_bus.dmem_rdata  = 32'h0;
        check_eq({tag, ":resp_valid"}, {31'b0, resp_valid}, 32'd1);
        check_eq({tag, ":resp_rdata"}, resp_rdata,          exp_rd);
        check_eq({tag, ":resp_fault"}, {31'b0, resp_fault}, 32'd0);
        check_eq({tag, ":resp_ready"}, {31'b0, req_ready},  32'd0);
        tick();
        check_eq({tag, ":pulse_end"},  {31'b0, resp_valid}, 32'd0);
        check_eq({tag, ":ready_back"}, {31'b0, req_ready},  32'd1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_width = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        dmem_bus.dmem_gnt    = 1'b0;
        dmem_bus.dmem_rvalid = 1'b0;
        dmem_bus.dmem_rdata  = 32'h0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check_idle_outputs("reset");

        // Stray gnt/rvalid while idle must not produce a response.
        dmem_bus.dmem_gnt    = 1'b1;
        dmem_bus.dmem_rvalid = 1'b1;
        tick();
        dmem_bus.dmem_gnt    = 1'b0;
        dmem_bus.dmem_rvalid = 1'b0;
        check_idle_outputs("idle_stray");

        //          tag      we    width   addr          wdata         rdata         exp_addr      be       exp_wd        exp_rd       wait same
        run_access("lb3",   1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 32'h0000_1000, 4'b1000, 32'h0,        32'hFFFF_FF80, 0, 1'b0);
        run_access("lbu3",  1'b0, 3'b100, 32'h0000_1003, 32'h0,        32'h80FF_1234, 32'h0000_1000, 4'b1000, 32'h0,        32'h0000_0080, 0, 1'b0);
        run_access("sh2",   1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'hFFFF_FFFF, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'h0,        0, 1'b0);
        run_access("lw_gw", 1'b0, 3'b010, 32'h0000_3000, 32'h0,        32'hDEAD_BEEF, 32'h0000_3000, 4'b1111, 32'h0,        32'hDEAD_BEEF, 5, 1'b0);
        run_access("lh_sc", 1'b0, 3'b001, 32'h0000_1002, 32'h0,        32'h80FF_1234, 32'h0000_1000, 4'b1100, 32'h0,        32'hFFFF_80FF, 0, 1'b1);
        run_access("lhu_b2b",1'b0,3'b101, 32'h0000_1002, 32'h0,        32'h80FF_1234, 32'h0000_1000, 4'b1100, 32'h0,        32'h0000_80FF, 0, 1'b0);
        run_access("sb1",   1'b1, 3'b000, 32'h0000_5001, 32'h1234_5678, 32'h0,        32'h0000_5000, 4'b0010, 32'h7878_7878, 32'h0,        0, 1'b0);
        run_access("sbu3",  1'b1, 3'b100, 32'h0000_5003, 32'h0000_00A5, 32'h0,        32'h0000_5000, 4'b1000, 32'hA5A5_A5A5, 32'h0,        1, 1'b0);
        run_access("sw0",   1'b1, 3'b010, 32'h0000_6000, 32'h0123_4567, 32'h0,        32'h0000_6000, 4'b1111, 32'h0123_4567, 32'h0,        0, 1'b1);
        run_access("lb1",   1'b0, 3'b000, 32'h0000_1001, 32'h0,        32'h80FF_1234, 32'h0000_1000, 4'b0010, 32'h0,        32'h0000_0012, 0, 1'b0);
        run_access("lh0",   1'b0, 3'b001, 32'h0000_1000, 32'h0,        32'h80FF_1234, 32'h0000_1000, 4'b0011, 32'h0,        32'h0000_1234, 0, 1'b0);
        run_access("l111",  1'b0, 3'b111, 32'h0000_7000, 32'h0,        32'hCAFE_F00D, 32'h0000_7000, 4'b1111, 32'h0,        32'hCAFE_F00D, 0, 1'b0);

`ifdef MISALIGN_TRAP_EN
        check_eq("trap:ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_width = 3'b010;
        req_addr  = 32'h0000_4002;
        tick();
        req_valid = 1'b0;
        check_eq("trap:dreq",  {31'b0, dmem_bus.dmem_req}, 32'd0);
        check_eq("trap:valid", {31'b0, resp_valid},        32'd1);
        check_eq("trap:fault", {31'b0, resp_fault},        32'd1);
        check_eq("trap:rdata", resp_rdata,                 32'd0);
        tick();
        check_eq("trap:pulse_end", {31'b0, resp_valid},        32'd0);
        check_eq("trap:fault_end", {31'b0, resp_fault},        32'd0);
        check_eq("trap:ready_back",{31'b0, req_ready},         32'd1);
        check_eq("trap:no_dreq",   {31'b0, dmem_bus.dmem_req}, 32'd0);
`else
        run_access("lw_mis", 1'b0, 3'b010, 32'h0000_4002, 32'h0, 32'h1122_3344, 32'h0000_4000, 4'b1111, 32'h0, 32'h1122_3344, 0, 1'b0);
        run_access("sh_mis", 1'b1, 3'b001, 32'h0000_2003, 32'h0000_C0DE, 32'h0, 32'h0000_2000, 4'b1100, 32'hC0DE_C0DE, 32'h0, 0, 1'b0);
`endif

        // Reset while waiting for rvalid; a late rvalid afterwards is dropped.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_width = 3'b010;
        req_addr  = 32'h0000_8000;
        tick();
        req_valid = 1'b0;
        dmem_bus.dmem_gnt = 1'b1;
        tick();
        dmem_bus.dmem_gnt = 1'b0;
        check_eq("rst_mid:in_wait", {31'b0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #2;
        check_idle_outputs("rst_mid:async");
        tick();
        rst_n = 1'b1;
        dmem_bus.dmem_rvalid = 1'b1;
        dmem_bus.dmem_rdata  = 32'hFFFF_FFFF;
        tick();
        dmem_bus.dmem_rvalid = 1'b0;
        check_idle_outputs("rst_mid:late_rvalid");
        tick();
        check_idle_outputs("rst_mid:settled");

        run_access("post_rst", 1'b0, 3'b000, 32'h0000_9002, 32'h0, 32'h00AB_0000, 32'h0000_9000, 4'b0100, 32'h0, 32'hFFFF_FFAB, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
